apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  APB3 requester: turns a simple valid/ready command stream into APB SETUP/ACCESS
//  transfers toward an APB completer (e.g. timer_top register file).
//  Returns one response (read data, error flag) per command.
//  Used in place of bench-driven APB pins, so firmware-style sequencers and the
//  timer share one bus master.
// PARAMETERS
//  ADDR_W          8   paddr / cmd_addr width
//  DATA_W          8   pwdata / prdata / cmd_wdata / rsp_rdata width
//  TIMEOUT_CYCLES  16  max ACCESS cycles without pready (APB_TIMEOUT_EN only; >=2)
// PORTS
//  pclk       in   1       clock; all logic on rising edge
//  preset     in   1       reset, synchronous, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       one-cycle pulse: transfer finished
//  rsp_rdata  out  DATA_W  read data (0 for writes and errors); valid with rsp_valid
//  rsp_err    out  1       timeout abort; valid with rsp_valid (0 without macro)
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction
//  paddr      out  ADDR_W  APB address
//  pwdata     out  DATA_W  APB write data
//  prdata     in   DATA_W  APB read data
//  pready     in   1       APB ready / wait-state control
// BEHAVIOUR
//  Reset (preset=1 at edge): state=IDLE; psel, penable, pwrite, paddr, pwdata,
//   rsp_valid, rsp_rdata, rsp_err = 0; cmd_ready=0 while preset=1.
//  All outputs registered except cmd_ready = (state==IDLE) && !preset.
//  FSM: IDLE --accept--> SETUP --1 cycle--> ACCESS --pready--> IDLE.
//   IDLE: psel=0, penable=0. On accept (edge N) capture cmd_write, cmd_addr and
//    cmd_wdata into pwrite, paddr and pwdata; psel=1 from cycle N+1 (SETUP).
//   SETUP: psel=1, penable=0; always -> ACCESS (penable=1 from N+2).
//   ACCESS: psel=1, penable=1; stay while pready=0 (wait states unlimited without macro).
//    pready=1: next edge -> IDLE, psel=penable=0, rsp_valid=1 for one cycle,
//    rsp_rdata = pwrite ? 0 : prdata sampled that edge, rsp_err=0.
//  Zero-wait latency: accept N -> rsp_valid at N+3; throughput 1 cmd / 3 cycles
//   (next accept possible in cycle rsp_valid is high).
//  paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle.
//   They keep their last value in IDLE (no return to 0).
//  cmd_* ignored outside IDLE; no command queue; rsp has no backpressure.
//  Reset mid-transfer: next edge psel=penable=0, state IDLE, no rsp_valid.
//   The in-flight command is dropped.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: a wait counter clears on SETUP->ACCESS and increments on
//   each ACCESS cycle with pready=0. After TIMEOUT_CYCLES consecutive such cycles:
//   next edge -> IDLE, psel=penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//   pready=1 in the threshold cycle completes normally (pready wins, rsp_err=0).
//  APB_TIMEOUT_EN undefined: no counter; rsp_err tied 0; ACCESS waits indefinitely.
// TESTING
//  1 Write, zero wait: cmd addr=0x00 wdata=0x35 write=1, pready=1 -> psel N+1,
//    penable N+2, paddr=0x00 pwdata=0x35 stable; rsp_valid N+3, rsp_rdata=0x00, err=0.
//  2 Read, 3 wait states: cmd addr=0x04 read, pready low 3 ACCESS cycles then high,
//    prdata=0xA5 -> penable high 4 cycles; rsp_valid at N+6, rsp_rdata=0xA5.
//  3 Back-to-back: cmd_valid held with write 0x01<-0x11 then read 0x01, pready=1 ->
//    second accept in cycle of first rsp_valid; psel low 1 cycle between transfers.
//  4 Reset in ACCESS (pready=0): preset pulse 1 cycle -> psel/penable 0 next edge,
//    no rsp_valid, cmd_ready=1 after preset falls.
//  5 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> rsp_valid and rsp_err=1
//    after 16 ACCESS cycles, rsp_rdata=0. pready=1 on cycle 16 -> normal rsp, err=0.
//  6 Without macro, pready low 100 cycles then high -> completes, rsp_err=0.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB3 requester: converts a valid/ready command stream into SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign cmd_ready = (state_q == StIdle) && !preset;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = StSetup;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StAccess: begin
                if (pready) begin
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end
`ifdef APB_TIMEOUT_EN
                // Threshold cycle without pready aborts; pready in that cycle wins above.
                else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: random commands, a behavioural APB completer
// and a queue of expected responses checked by an independent monitor.
module tb_apb_cmd_master;

    localparam int T = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;

    apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(T)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        bit       write;
        bit [7:0] addr;
        bit [7:0] wdata;
        int       waits;
    } cmd_t;
    typedef struct {
        bit [7:0] rdata;
        bit       err;
        int       cyc;
    } exp_t;

    cmd_t     cmd_q[$];
    exp_t     exp_q[$];
    bit [7:0] model_mem [256];
    bit [7:0] slave_mem [256];
    int       checks = 0;
    int       failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural APB completer: inserts the requested wait states, backs reads with memory.
    cmd_t cur;
    int   acc_cnt;
    always @(negedge pclk) begin
        if (preset) begin
            acc_cnt = 0;
            pready  = 1'b0;
            prdata  = 8'h00;
        end else if (psel && !penable) begin
            if (cmd_q.size() == 0) begin
                chk("setup_without_cmd", 1, 0);
            end else begin
                cur = cmd_q.pop_front();
                chk("setup_paddr", paddr, cur.addr);
                chk("setup_pwrite", pwrite, cur.write);
                if (cur.write) chk("setup_pwdata", pwdata, cur.wdata);
            end
            acc_cnt = 0;
            pready  = 1'($urandom);
            prdata  = 8'($urandom);
        end else if (psel && penable) begin
            if (paddr !== cur.addr || pwrite !== cur.write || (cur.write && pwdata !== cur.wdata))
                chk("access_stable", {paddr, 7'd0, pwrite, pwdata}, {cur.addr, 7'd0, cur.write,
                    cur.write ? cur.wdata : pwdata});
            if (acc_cnt == cur.waits) begin
                pready = 1'b1;
                prdata = slave_mem[paddr];
                if (pwrite) slave_mem[paddr] = pwdata;
            end else begin
                pready = 1'b0;
                prdata = 8'($urandom);
            end
            acc_cnt++;
        end else begin
            if (penable) chk("penable_without_psel", penable, 0);
            acc_cnt = 0;
            pready  = 1'($urandom);
            prdata  = 8'($urandom);
        end
    end

    // Monitor: every response must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge pclk) begin
        if (!preset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_psel_low", {psel, penable}, 0);
            end
        end
    end

    // Drives one command (called at a negedge); leaves the bus idle one negedge after accept.
    task automatic send(input bit w, input bit [7:0] a, input bit [7:0] d, input int waits,
                        output int acc_cyc);
        int   bound;
        bit   err;
        exp_t x;
        bound     = 0;
        cmd_valid = 1'b1;
        while (!cmd_ready && bound < 400) begin
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
            @(negedge pclk);
            bound++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc_cyc   = -1;
            return;
        end
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc_cyc   = cyc;
        err       = TO_EN && (waits >= T);
        x.err     = err;
        x.rdata   = (w || err) ? 8'h00 : model_mem[a];
        x.cyc     = err ? cyc + 2 + T : cyc + 3 + waits;
        if (w && !err) model_mem[a] = d;
        exp_q.push_back(x);
        cmd_q.push_back('{w, a, d, waits});
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    initial begin
        int a0, a1, r, waits, bound;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'(i * 7 + 3);
            slave_mem[i] = 8'(i * 7 + 3);
        end
        model_mem[4] = 8'hA5;
        slave_mem[4] = 8'hA5;
        preset    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h5A;
        cmd_wdata = 8'hC3;
        repeat (3) @(negedge pclk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_pwrite", pwrite, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        cmd_valid = 1'b0;
        preset    = 1'b0;
        #1;
        chk("post_reset_ready", cmd_ready, 1);
        @(negedge pclk);

        // Zero-wait write, then read with three wait states.
        send(1'b1, 8'h00, 8'h35, 0, a0);
        @(negedge pclk);
        chk("w_psel_penable", {psel, penable}, 2'b11);
        repeat (3) @(negedge pclk);
        send(1'b0, 8'h04, 8'h00, 3, a0);
        repeat (8) @(negedge pclk);

        // Back-to-back: second accept lands in the first response cycle.
        send(1'b1, 8'h01, 8'h11, 0, a0);
        send(1'b0, 8'h01, 8'h00, 0, a1);
        chk("b2b_accept_gap", a1 - a0, 3);
        repeat (4) @(negedge pclk);

        // Reset while stalled in ACCESS drops the command.
        send(1'b0, 8'h22, 8'h00, 50, a0);
        bound = 0;
        while (!(psel && penable) && bound < 20) begin
            @(negedge pclk);
            bound++;
        end
        chk("reach_access", {psel, penable}, 2'b11);
        @(negedge pclk);
        preset = 1'b1;
        exp_q.delete();
        cmd_q.delete();
        #1;
        chk("mid_reset_ready", cmd_ready, 0);
        @(negedge pclk);
        chk("mid_reset_bus", {psel, penable, rsp_valid}, 0);
        preset = 1'b0;
        #1;
        chk("mid_reset_ready_after", cmd_ready, 1);
        repeat (5) @(negedge pclk);

`ifdef APB_TIMEOUT_EN
        send(1'b0, 8'h04, 8'h00, 1000, a0);
        send(1'b0, 8'h04, 8'h00, T - 1, a0);
        send(1'b1, 8'h09, 8'h66, T, a0);
`else
        send(1'b0, 8'h04, 8'h00, 100, a0);
`endif

        for (int n = 0; n < 80; n++) begin
            r     = int'($urandom_range(0, 9));
            waits = (r < 6) ? 0 : (r < 9) ? int'($urandom_range(1, 4))
                                          : int'($urandom_range(T - 2, T + 4));
            send(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), waits, a0);
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        bound = 0;
        while (exp_q.size() != 0 && bound < 2000) begin
            @(negedge pclk);
            bound++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        repeat (5) @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
